mc_control_fsm: RTL
===================

Name: mc_control_fsm

Overview:
- Multi-cycle MIPS main controller.
- Sequences the shared datapath (PC, IR, register file, ALU, sign-extend unit, unified memory) through fetch, decode, execute, memory and writeback states.
- Owns the extend-mode select (ext_op) driven into the immediate extender.
- Stalls on a ready-based memory handshake.

Parameters:
- MEM_TIMEOUT, 0, maximum wait cycles for mem_ready in a memory state; 0 disables the timeout.
- TO_W, 8, width of the wait counter; MEM_TIMEOUT < 2^TO_W.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  synchronous active-low reset.
- opcode  in  6  IR[31:26]; stable from DECODE until return to FETCH.
- mem_ready  in  1  memory completes the current access this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if ALU zero (beq).
- pc_write_cond_n  out  1  PC load if ALU not zero (bne).
- iord  out  1  memory address mux: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  IR load.
- mem_to_reg  out  1  register write data: 1 = MDR, 0 = ALUOut.
- reg_dst  out  1  destination register: 1 = rd, 0 = rt.
- reg_write  out  1  register file write enable.
- alu_src_a  out  1  ALU A: 0 = PC, 1 = reg A.
- alu_src_b  out  2  ALU B: 00 = reg B, 01 = const 4, 10 = ext imm, 11 = ext imm << 2.
- alu_op  out  2  ALU op: 00 = add, 01 = sub, 10 = funct decode, 11 = opcode decode.
- pc_source  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- ext_op  out  1  extender mode: 1 = sign-extend, 0 = zero-extend.
- state  out  4  current state encoding, for debug.
- illegal_op  out  1  sticky; set on an undecodable opcode.
- bus_error  out  1  sticky; set on a memory timeout.

Behaviour:
Reset
- rst_n sampled low at a rising edge: state = FETCH (0), wait counter = 0, illegal_op = 0, bus_error = 0.
- While rst_n is low, all control outputs are forced to 0 combinationally.

State encoding
- FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, R_EXEC 6, R_WB 7, BRANCH 8, JUMP 9, IMM_EXEC 10, IMM_WB 11.
- Codes 12-15 are unreachable; if entered, next state is FETCH.

Outputs
- Moore decode from state, except ir_write and pc_write in FETCH, which are also gated by mem_ready.
- Every output not listed for a state is 0.

Per-state outputs and transitions
- FETCH: mem_read=1, iord=0, alu_src_b=01, alu_op=00, pc_source=00. If mem_ready: ir_write=1, pc_write=1, go to DECODE. Otherwise stay.
- DECODE: alu_src_b=11, ext_op=1, alu_op=00 (branch-target precompute). Next state by opcode:
  - 000000 -> R_EXEC
  - 100011 (lw), 101011 (sw) -> MEM_ADDR
  - 000100 (beq), 000101 (bne) -> BRANCH
  - 000010 (j) -> JUMP
  - 001000 (addi), 001010 (slti) -> IMM_EXEC
  - any other opcode: set illegal_op, go to FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, ext_op=1, alu_op=00. lw -> MEM_READ, sw -> MEM_WRITE.
- MEM_READ: mem_read=1, iord=1. mem_ready -> MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0. -> FETCH.
- MEM_WRITE: mem_write=1, iord=1. mem_ready -> FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. -> R_WB.
- R_WB: reg_write=1, reg_dst=1. -> FETCH.
- BRANCH: alu_src_a=1, alu_op=01, pc_source=01; pc_write_cond=1 for beq, pc_write_cond_n=1 for bne. -> FETCH.
- JUMP: pc_source=10, pc_write=1. -> FETCH.
- IMM_EXEC: alu_src_a=1, alu_src_b=10, alu_op=11, ext_op=1. -> IMM_WB.
- IMM_WB: reg_write=1, reg_dst=0, mem_to_reg=0. -> FETCH.

Wait states (FETCH, MEM_READ, MEM_WRITE)
- The wait counter clears on entry to a wait state.
- It increments each cycle mem_ready is low.
- If MEM_TIMEOUT != 0 and the counter equals MEM_TIMEOUT with mem_ready still low: set bus_error, go to FETCH. No ir_write, pc_write or reg_write occurs for the abandoned access.
- mem_ready in the same cycle the limit is reached takes priority: the access completes normally.

Fixed latencies (mem_ready = 1 on first request cycle)
- R-type 4 cycles, lw 5, sw 4, beq/bne 3, j 3, addi/slti 4.

Reset mid-operation
- Reset in any state aborts to FETCH next cycle with no pending writes.

Optional Feature:
- Macro: ZEXT_LOGIC_IMM_EN.
- Defined: DECODE routes 001100 (andi), 001101 (ori) and 001110 (xori) to IMM_EXEC. For these opcodes ext_op=0 in IMM_EXEC; alu_op=11 as for the other immediates.
- Not defined: those three opcodes are illegal (illegal_op set, return to FETCH).

Test Plan:
- Reset: hold rst_n=0 for 2 edges, release, mem_ready=1 -> state=0 and outputs 0 during reset. First FETCH cycle shows mem_read=1, ir_write=1, pc_write=1.
- lw, opcode=100011, mem_ready=1 -> state sequence 0,1,2,3,4,0. ext_op=1 and alu_src_b=10 in MEM_ADDR; reg_write=1 and mem_to_reg=1 only in MEM_WB.
- Wait states, sw with mem_ready low for 3 cycles in MEM_WRITE, MEM_TIMEOUT=0 -> mem_write held for 4 cycles, then FETCH. bus_error stays 0.
- Timeout, MEM_TIMEOUT=5, mem_ready stuck low in FETCH -> bus_error=1 after 5 wait cycles, state re-enters FETCH, ir_write never pulses.
- Branches: beq and bne -> 3-cycle sequence 0,1,8 with pc_write_cond=1 (beq) or pc_write_cond_n=1 (bne) in BRANCH, pc_source=01.
- Illegal/optional opcodes: opcode=001101 (ori) -> without ZEXT_LOGIC_IMM_EN, illegal_op=1 after DECODE. With the macro defined, sequence 0,1,10,11 with ext_op=0 in IMM_EXEC; addi shows ext_op=1.

Source files
------------

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS main controller: sequences fetch/decode/execute/memory/writeback
// with a ready-based memory handshake. Optional build macro: ZEXT_LOGIC_IMM_EN.
module mc_control_fsm #(
    parameter int unsigned MEM_TIMEOUT = 0,
    parameter int unsigned TO_W        = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       pc_write_cond_n,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       ext_op,
    output logic [3:0] state,
    output logic       illegal_op,
    output logic       bus_error
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

`ifdef ZEXT_LOGIC_IMM_EN
    localparam bit ZEXT_EN = 1'b1;
`else
    localparam bit ZEXT_EN = 1'b0;
`endif

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_IMM_EXEC  = 4'd10,
        S_IMM_WB    = 4'd11
    } state_t;

    state_t            state_q, state_d;
    logic [TO_W-1:0]   wait_q, wait_d;
    logic              illegal_q, bus_err_q;
    logic              set_illegal, set_bus_err;
    logic              timeout;
    logic              zext_op;

    // Abandon a stalled access once the wait counter hits the limit
    assign timeout = (MEM_TIMEOUT != 0) && (wait_q == TO_W'(MEM_TIMEOUT)) && !mem_ready;
    assign zext_op = ZEXT_EN && ((opcode == OP_ANDI) || (opcode == OP_ORI) || (opcode == OP_XORI));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            wait_q    <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_q | set_illegal;
            bus_err_q <= bus_err_q | set_bus_err;
        end
    end

    // Next state and Moore outputs; wait_d only advances while stalling in place
    always_comb begin
        state_d         = state_q;
        wait_d          = '0;
        set_illegal     = 1'b0;
        set_bus_err     = 1'b0;
        pc_write        = 1'b0;
        pc_write_cond   = 1'b0;
        pc_write_cond_n = 1'b0;
        iord            = 1'b0;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        ir_write        = 1'b0;
        mem_to_reg      = 1'b0;
        reg_dst         = 1'b0;
        reg_write       = 1'b0;
        alu_src_a       = 1'b0;
        alu_src_b       = 2'b00;
        alu_op          = 2'b00;
        pc_source       = 2'b00;
        ext_op          = 1'b0;
        if (rst_n) begin
            case (state_q)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_d  = S_DECODE;
                    end else if (timeout) begin
                        set_bus_err = 1'b1;
                        state_d     = S_FETCH;
                    end else begin
                        wait_d = wait_q + TO_W'(1);
                    end
                end
                S_DECODE: begin
                    alu_src_b = 2'b11;
                    ext_op    = 1'b1;
                    case (opcode)
                        OP_RTYPE:        state_d = S_R_EXEC;
                        OP_LW, OP_SW:    state_d = S_MEM_ADDR;
                        OP_BEQ, OP_BNE:  state_d = S_BRANCH;
                        OP_J:            state_d = S_JUMP;
                        OP_ADDI, OP_SLTI: state_d = S_IMM_EXEC;
                        default: begin
                            if (zext_op) begin
                                state_d = S_IMM_EXEC;
                            end else begin
                                set_illegal = 1'b1;
                                state_d     = S_FETCH;
                            end
                        end
                    endcase
                end
                S_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    ext_op    = 1'b1;
                    state_d   = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
                end
                S_MEM_READ: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                    if (mem_ready) begin
                        state_d = S_MEM_WB;
                    end else if (timeout) begin
                        set_bus_err = 1'b1;
                        state_d     = S_FETCH;
                    end else begin
                        wait_d = wait_q + TO_W'(1);
                    end
                end
                S_MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    state_d    = S_FETCH;
                end
                S_MEM_WRITE: begin
                    mem_write = 1'b1;
                    iord      = 1'b1;
                    if (mem_ready) begin
                        state_d = S_FETCH;
                    end else if (timeout) begin
                        set_bus_err = 1'b1;
                        state_d     = S_FETCH;
                    end else begin
                        wait_d = wait_q + TO_W'(1);
                    end
                end
                S_R_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b10;
                    state_d   = S_R_WB;
                end
                S_R_WB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                    state_d   = S_FETCH;
                end
                S_BRANCH: begin
                    alu_src_a       = 1'b1;
                    alu_op          = 2'b01;
                    pc_source       = 2'b01;
                    pc_write_cond   = (opcode == OP_BEQ);
                    pc_write_cond_n = (opcode == OP_BNE);
                    state_d         = S_FETCH;
                end
                S_JUMP: begin
                    pc_source = 2'b10;
                    pc_write  = 1'b1;
                    state_d   = S_FETCH;
                end
                S_IMM_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    alu_op    = 2'b11;
                    ext_op    = !zext_op;
                    state_d   = S_IMM_WB;
                end
                S_IMM_WB: begin
                    reg_write = 1'b1;
                    state_d   = S_FETCH;
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

    assign state      = state_q;
    assign illegal_op = illegal_q;
    assign bus_error  = bus_err_q;

endmodule
